// File: rtl/fft_ctrl_pkg.sv
// Shared types for the butterfly-stage sequencer: FSM states, the per-beat tag
// carried alongside the datapath, and the credit counter width.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Wide enough for any practical frame size; the top uses the low IDX_W bits.
  localparam int TAG_IDX_W = 8;

  typedef struct packed {
    logic                 valid;
    logic                 sop;
    logic                 eop;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

  function automatic int credit_cnt_w(input int credits);
    return (credits < 1) ? 1 : $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/fft_tag_delay.sv
// Fixed-latency shift register of beat tags matching the butterfly datapath depth.
// Latency PIPE_LAT edges, no stall; synchronous clear empties every stage.
module fft_tag_delay
  import fft_ctrl_pkg::*;
#(
  parameter int PIPE_LAT = 1
) (
  input  logic clk,
  input  logic clr,
  input  tag_t in_tag,
  output tag_t out_tag
);

  tag_t pipe_q [PIPE_LAT];
  tag_t pipe_d [PIPE_LAT];

  always_comb begin
    pipe_d[0] = in_tag;
    for (int i = 1; i < PIPE_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PIPE_LAT; i++) begin
      if (clr) pipe_q[i] <= '0;
      else     pipe_q[i] <= pipe_d[i];
    end
  end

  assign out_tag = pipe_q[PIPE_LAT-1];

endmodule

// File: rtl/fft_bfly_stage_ctrl.sv
// Sequencer for one radix-2 butterfly stage: frames 16-lane blocks, gates them on
// downstream credits, and re-times sop/eop/index tags to the datapath output.
module fft_bfly_stage_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int PIPE_LAT      = 1,
  parameter int BLK_PER_FRAME = 4,
  parameter int CREDITS       = 4,
  parameter int IDX_W         = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sop,
  output logic             in_ready,
  input  logic             credit_ret,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  output logic [IDX_W-1:0] tw_addr,
  output logic             frame_done,
  output logic             busy,
  output logic             err_proto,
  output logic             err_credit
);

  localparam int               CNT_W      = credit_cnt_w(CREDITS);
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(CREDITS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(BLK_PER_FRAME - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] blk_cnt_q, blk_cnt_d;
  logic [CNT_W-1:0] credit_q, credit_d;
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic             err_credit_q, err_credit_d;
  logic             err_proto_q, err_proto_d;
  logic             frame_done_q, frame_done_d;
  logic             fire;
  logic             credit_ovf;
  logic             idx_unused;
  tag_t             tag_in, tag_out;

  assign in_ready = (state_q == IDLE || state_q == RUN) && (credit_q != '0) && !rst;
  assign fire     = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    blk_cnt_d    = blk_cnt_q;
    err_proto_d  = 1'b0;
    frame_done_d = 1'b0;
    tag_in       = '0;
    case (state_q)
      IDLE: begin
        if (fire) begin
          if (in_sop) begin
            tag_in.valid = 1'b1;
            tag_in.sop   = 1'b1;
            if (BLK_PER_FRAME == 1) begin
              tag_in.eop = 1'b1;
              blk_cnt_d  = '0;
              state_d    = DRAIN;
            end else begin
              blk_cnt_d = IDX_W'(1);
              state_d   = RUN;
            end
          end else begin
            // Orphan beat: its credit is still spent, downstream returns it.
            err_proto_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (fire) begin
          tag_in.valid = 1'b1;
          tag_in.idx   = TAG_IDX_W'(blk_cnt_q);
          err_proto_d  = in_sop;
          if (blk_cnt_q == LAST_IDX) begin
            tag_in.eop = 1'b1;
            blk_cnt_d  = '0;
            state_d    = DRAIN;
          end else begin
            blk_cnt_d = blk_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // Stay one cycle past the eop beat so frame_done lines up with leaving DRAIN.
        frame_done_d = tag_out.valid && tag_out.eop;
        if (frame_done_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    credit_d     = credit_q;
    err_credit_d = err_credit_q;
    credit_ovf   = credit_ret && (credit_q == CREDIT_MAX);
    if (credit_ovf) err_credit_d = 1'b1;
    case ({fire, credit_ret && !credit_ovf})
      2'b10:   credit_d = credit_q - 1'b1;
      2'b01:   credit_d = credit_q + 1'b1;
      default: credit_d = credit_q;
    endcase
    last_idx_d = tag_out.valid ? tag_out.idx[IDX_W-1:0] : last_idx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      blk_cnt_q    <= '0;
      credit_q     <= CREDIT_MAX;
      last_idx_q   <= '0;
      err_credit_q <= 1'b0;
      err_proto_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      blk_cnt_q    <= blk_cnt_d;
      credit_q     <= credit_d;
      last_idx_q   <= last_idx_d;
      err_credit_q <= err_credit_d;
      err_proto_q  <= err_proto_d;
      frame_done_q <= frame_done_d;
    end
  end

  fft_tag_delay #(
    .PIPE_LAT (PIPE_LAT)
  ) u_tag_delay (
    .clk     (clk),
    .clr     (rst),
    .in_tag  (tag_in),
    .out_tag (tag_out)
  );

  assign idx_unused = ^tag_out.idx;

  assign out_valid  = tag_out.valid;
  assign out_sop    = tag_out.sop;
  assign out_eop    = tag_out.eop;
  assign tw_addr    = tag_out.valid ? tag_out.idx[IDX_W-1:0] : last_idx_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE);
  assign err_proto  = err_proto_q;
  assign err_credit = err_credit_q;

endmodule

// File: tb/tb_fft_bfly_stage_ctrl.sv
// Scoreboarded bench: instance A uses default parameters, instance B uses
// PIPE_LAT=3 with single-block frames.
module tb_fft_bfly_stage_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int cyc;
    int sop;
    int eop;
    int idx;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  logic       rst_a, in_valid_a, in_sop_a, in_ready_a, credit_ret_a, man_ret_a, tie_ret_a;
  logic       out_valid_a, out_sop_a, out_eop_a, frame_done_a, busy_a, err_proto_a, err_credit_a;
  logic [1:0] tw_addr_a;
  assign credit_ret_a = tie_ret_a ? out_valid_a : man_ret_a;

  logic       rst_b, in_valid_b, in_sop_b, in_ready_b, credit_ret_b;
  logic       out_valid_b, out_sop_b, out_eop_b, frame_done_b, busy_b, err_proto_b, err_credit_b;
  logic [0:0] tw_addr_b;
  assign credit_ret_b = 1'b0;

  fft_bfly_stage_ctrl u_dut_a (
    .clk        (clk),
    .rst        (rst_a),
    .in_valid   (in_valid_a),
    .in_sop     (in_sop_a),
    .in_ready   (in_ready_a),
    .credit_ret (credit_ret_a),
    .out_valid  (out_valid_a),
    .out_sop    (out_sop_a),
    .out_eop    (out_eop_a),
    .tw_addr    (tw_addr_a),
    .frame_done (frame_done_a),
    .busy       (busy_a),
    .err_proto  (err_proto_a),
    .err_credit (err_credit_a)
  );

  fft_bfly_stage_ctrl #(
    .PIPE_LAT      (3),
    .BLK_PER_FRAME (1),
    .CREDITS       (4),
    .IDX_W         (1)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .in_valid   (in_valid_b),
    .in_sop     (in_sop_b),
    .in_ready   (in_ready_b),
    .credit_ret (credit_ret_b),
    .out_valid  (out_valid_b),
    .out_sop    (out_sop_b),
    .out_eop    (out_eop_b),
    .tw_addr    (tw_addr_b),
    .frame_done (frame_done_b),
    .busy       (busy_b),
    .err_proto  (err_proto_b),
    .err_credit (err_credit_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: every presented output beat must match the head of its queue.
  always @(negedge clk) begin
    if (out_valid_a === 1'b1) begin
      if (q_a.size() == 0) begin
        chk("a_out_valid_unexpected", int'(out_valid_a), 0);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_out_cycle", cyc, e.cyc);
        chk("a_out_sop", int'(out_sop_a), e.sop);
        chk("a_out_eop", int'(out_eop_a), e.eop);
        chk("a_tw_addr", int'(tw_addr_a), e.idx);
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid_b === 1'b1) begin
      if (q_b.size() == 0) begin
        chk("b_out_valid_unexpected", int'(out_valid_b), 0);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("b_out_cycle", cyc, e.cyc);
        chk("b_out_sop", int'(out_sop_b), e.sop);
        chk("b_out_eop", int'(out_eop_b), e.eop);
        chk("b_tw_addr", int'(tw_addr_b), e.idx);
      end
    end
  end

  task automatic step_a(input int v, input int s, input int r, input int ret, input int rdy);
    @(negedge clk);
    in_valid_a = (v != 0);
    in_sop_a   = (s != 0);
    rst_a      = (r != 0);
    man_ret_a  = (ret != 0);
    #1;
    chk("a_in_ready", int'(in_ready_a), rdy);
  endtask

  task automatic push_a(input int s, input int e, input int idx);
    q_a.push_back('{cyc + 1, s, e, idx});
  endtask

  task automatic step_b(input int v, input int s, input int r, input int rdy);
    @(negedge clk);
    in_valid_b = (v != 0);
    in_sop_b   = (s != 0);
    rst_b      = (r != 0);
    #1;
    chk("b_in_ready", int'(in_ready_b), rdy);
  endtask

  task automatic check_a_idle_outputs(input string tag);
    chk({tag, "_out_valid"},  int'(out_valid_a),  0);
    chk({tag, "_out_sop"},    int'(out_sop_a),    0);
    chk({tag, "_out_eop"},    int'(out_eop_a),    0);
    chk({tag, "_tw_addr"},    int'(tw_addr_a),    0);
    chk({tag, "_frame_done"}, int'(frame_done_a), 0);
    chk({tag, "_busy"},       int'(busy_a),       0);
    chk({tag, "_err_proto"},  int'(err_proto_a),  0);
    chk({tag, "_err_credit"}, int'(err_credit_a), 0);
  endtask

  initial begin
    rst_a = 1'b1; in_valid_a = 1'b0; in_sop_a = 1'b0; man_ret_a = 1'b0; tie_ret_a = 1'b0;
    rst_b = 1'b1; in_valid_b = 1'b0; in_sop_b = 1'b0;

    step_a(0, 0, 1, 0, 0);
    step_a(0, 0, 1, 0, 0);
    step_a(0, 0, 0, 0, 1);
    check_a_idle_outputs("a_reset");

    // Nominal frame with credits returned as blocks leave.
    tie_ret_a = 1'b1;
    step_a(1, 1, 0, 0, 1); push_a(1, 0, 0);
    step_a(1, 0, 0, 0, 1); push_a(0, 0, 1);
    chk("a_busy_run", int'(busy_a), 1);
    step_a(1, 0, 0, 0, 1); push_a(0, 0, 2);
    step_a(1, 0, 0, 0, 1); push_a(0, 1, 3);
    step_a(0, 0, 0, 0, 0);
    chk("a_frame_done_early", int'(frame_done_a), 0);
    step_a(0, 0, 0, 0, 0);
    chk("a_frame_done", int'(frame_done_a), 1);
    step_a(0, 0, 0, 0, 1);
    chk("a_frame_done_clear", int'(frame_done_a), 0);
    chk("a_busy_idle", int'(busy_a), 0);
    tie_ret_a = 1'b0;

    // Credit stall: two frames offered, no returns.
    step_a(1, 1, 0, 0, 1); push_a(1, 0, 0);
    step_a(1, 0, 0, 0, 1); push_a(0, 0, 1);
    step_a(1, 0, 0, 0, 1); push_a(0, 0, 2);
    step_a(1, 0, 0, 0, 1); push_a(0, 1, 3);
    for (int i = 0; i < 4; i++) step_a(1, 1, 0, 0, 0);
    chk("a_idle_no_credit", int'(busy_a), 0);
    step_a(1, 1, 0, 1, 0);
    step_a(1, 1, 0, 0, 1); push_a(1, 0, 0);
    step_a(1, 0, 0, 0, 0);
    chk("a_busy_stalled", int'(busy_a), 1);
    step_a(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step_a(0, 0, 0, 1, int'(i != 0));

    // sop on the third block is flagged but does not restart the frame.
    step_a(1, 0, 0, 0, 1); push_a(0, 0, 1);
    step_a(1, 1, 0, 0, 1); push_a(0, 0, 2);
    step_a(1, 0, 0, 0, 1); push_a(0, 1, 3);
    chk("a_err_proto_run", int'(err_proto_a), 1);
    step_a(0, 0, 0, 0, 0);
    chk("a_err_proto_pulse", int'(err_proto_a), 0);
    step_a(0, 0, 0, 0, 0);
    chk("a_frame_done_2", int'(frame_done_a), 1);

    // Fire and return together at one credit, then overflow.
    step_a(1, 1, 0, 1, 1); push_a(1, 0, 0);
    step_a(1, 0, 0, 0, 1); push_a(0, 0, 1);
    step_a(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step_a(0, 0, 0, 1, int'(i != 0));
    step_a(0, 0, 0, 1, 1);
    chk("a_err_credit_pre", int'(err_credit_a), 0);
    step_a(0, 0, 0, 0, 1);
    chk("a_err_credit_set", int'(err_credit_a), 1);
    for (int i = 0; i < 3; i++) step_a(0, 0, 0, 0, 1);
    chk("a_err_credit_sticky", int'(err_credit_a), 1);
    step_a(1, 0, 0, 0, 1); push_a(0, 0, 2);
    step_a(1, 0, 0, 0, 1); push_a(0, 1, 3);
    step_a(0, 0, 0, 0, 0);
    step_a(0, 0, 0, 0, 0);
    step_a(0, 0, 0, 0, 1);

    // Orphan beat in IDLE.
    step_a(1, 0, 0, 0, 1);
    step_a(0, 0, 0, 0, 1);
    chk("a_err_proto_idle", int'(err_proto_a), 1);
    chk("a_orphan_no_valid", int'(out_valid_a), 0);
    chk("a_orphan_stay_idle", int'(busy_a), 0);
    step_a(0, 0, 0, 0, 1);
    chk("a_err_proto_idle_clr", int'(err_proto_a), 0);

    // Reset mid-frame after two fires.
    step_a(0, 0, 0, 1, 1);
    step_a(1, 1, 0, 0, 1); push_a(1, 0, 0);
    step_a(1, 0, 0, 0, 1); push_a(0, 0, 1);
    step_a(0, 0, 1, 0, 0);
    step_a(0, 0, 0, 0, 1);
    check_a_idle_outputs("a_midrst");
    step_a(1, 1, 0, 0, 1); push_a(1, 0, 0);
    step_a(1, 0, 0, 0, 1); push_a(0, 0, 1);
    step_a(1, 0, 0, 0, 1); push_a(0, 0, 2);
    step_a(1, 0, 0, 0, 1); push_a(0, 1, 3);
    step_a(1, 1, 0, 0, 0);
    step_a(1, 1, 0, 0, 0);
    chk("a_frame_done_post_rst", int'(frame_done_a), 1);
    step_a(1, 1, 0, 0, 0);
    step_a(0, 0, 0, 0, 0);
    chk("a_queue_drained", q_a.size(), 0);

    // Instance B: deep pipe, single-block frames.
    step_b(0, 0, 1, 0);
    step_b(0, 0, 0, 1);
    chk("b_reset_out_valid", int'(out_valid_b), 0);
    chk("b_reset_busy", int'(busy_b), 0);
    step_b(1, 1, 0, 1); q_b.push_back('{cyc + 3, 1, 1, 0});
    step_b(0, 0, 0, 0);
    chk("b_busy_drain", int'(busy_b), 1);
    step_b(0, 0, 0, 0);
    step_b(0, 0, 0, 0);
    chk("b_frame_done_early", int'(frame_done_b), 0);
    step_b(0, 0, 0, 0);
    chk("b_frame_done", int'(frame_done_b), 1);
    step_b(0, 0, 0, 1);
    chk("b_frame_done_clear", int'(frame_done_b), 0);
    chk("b_busy_idle", int'(busy_b), 0);
    chk("b_err_proto", int'(err_proto_b), 0);
    chk("b_queue_drained", q_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
